// File: rtl/int_alu_pkg.sv
// Shared types and helpers for the integer ALU blocks: FSM states, operand
// mode encodings and counter sizing.
package int_alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_INC = 1'b0;
   localparam logic MODE_ADD = 1'b1;

   // A single-chunk datapath still needs a one-bit counter to keep widths legal.
   function automatic int cnt_width(input int num_chunks);
      return (num_chunks <= 1) ? 1 : $clog2(num_chunks);
   endfunction

endpackage

// File: rtl/int_chunk_adder.sv
// Combinational ripple-carry adder for one chunk of the serial adder.
module int_chunk_adder #(
   parameter int CHUNK_WIDTH = 8
) (
   input  logic [CHUNK_WIDTH-1:0] a,
   input  logic [CHUNK_WIDTH-1:0] b,
   input  logic                   carry_in,
   output logic [CHUNK_WIDTH-1:0] sum,
   output logic                   carry_out
);

   logic [CHUNK_WIDTH:0] carry;

   assign carry[0] = carry_in;

   for (genvar i = 0; i < CHUNK_WIDTH; i++) begin : g_bit
      assign sum[i]       = a[i] ^ b[i] ^ carry[i];
      assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign carry_out = carry[CHUNK_WIDTH];

endmodule

// File: rtl/int_serial_adder.sv
// Multi-cycle adder processing CHUNK_WIDTH bits per cycle through one shared
// chunk adder. Optional overflow port enabled by INT_SERIAL_ADDER_OVF_EN.
module int_serial_adder
   import int_alu_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int CHUNK_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  mode,
   input  logic [DATA_WIDTH-1:0] data_a,
   input  logic [DATA_WIDTH-1:0] data_b,
   input  logic                  carry_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] sum,
   output logic                  carry_out
`ifdef INT_SERIAL_ADDER_OVF_EN
   ,
   output logic                  overflow
`endif
);

   localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
   localparam int CNT_W      = cnt_width(NUM_CHUNKS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high. in_ready is high only in IDLE; out_valid only in DONE, and the
   // result stays put until out_ready is seen.

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   a_q, b_q, sum_q;
   logic                    carry_q, carry_out_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [CHUNK_WIDTH-1:0]  a_chunk, b_chunk, chunk_sum;
   logic                    chunk_cout;
   logic                    last_chunk;

   assign last_chunk = (cnt_q == LAST_CNT);

   // Constant-slice mux keeps the chunk selection free of variable part-selects.
   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int g = 0; g < NUM_CHUNKS; g++) begin
         if (cnt_q == CNT_W'(g)) begin
            a_chunk = a_q[g*CHUNK_WIDTH +: CHUNK_WIDTH];
            b_chunk = b_q[g*CHUNK_WIDTH +: CHUNK_WIDTH];
         end
      end
   end

   int_chunk_adder #(
      .CHUNK_WIDTH (CHUNK_WIDTH)
   ) u_chunk_adder (
      .a         (a_chunk),
      .b         (b_chunk),
      .carry_in  (carry_q),
      .sum       (chunk_sum),
      .carry_out (chunk_cout)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid)   state_d = BUSY;
         BUSY:    if (last_chunk) state_d = DONE;
         DONE:    if (out_ready)  state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         sum_q       <= '0;
         carry_out_q <= 1'b0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q         <= data_a;
                  b_q         <= (mode == MODE_ADD) ? data_b : '0;
                  carry_q     <= carry_in;
                  cnt_q       <= '0;
                  sum_q       <= '0;
                  carry_out_q <= 1'b0;
               end
            end
            BUSY: begin
               for (int g = 0; g < NUM_CHUNKS; g++) begin
                  if (cnt_q == CNT_W'(g)) begin
                     sum_q[g*CHUNK_WIDTH +: CHUNK_WIDTH] <= chunk_sum;
                  end
               end
               carry_q <= chunk_cout;
               if (last_chunk) begin
                  cnt_q       <= '0;
                  carry_out_q <= chunk_cout;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign carry_out = carry_out_q;

`ifdef INT_SERIAL_ADDER_OVF_EN
   logic overflow_q;

   // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else if (state_q == IDLE && in_valid) begin
         overflow_q <= 1'b0;
      end else if (state_q == BUSY && last_chunk) begin
         overflow_q <= chunk_cout ^ (a_chunk[CHUNK_WIDTH-1] ^ b_chunk[CHUNK_WIDTH-1]
                                     ^ chunk_sum[CHUNK_WIDTH-1]);
      end
   end

   assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_int_serial_adder.sv
// Directed self-checking bench for int_serial_adder: an 8-bit-chunk instance
// and a single-chunk instance share clock and reset.
module tb_int_serial_adder;

   localparam int DW = 32;
   localparam int CW = 8;
   localparam int N  = DW / CW;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT 0: 8-bit chunks ----------------
   logic          in_valid0, in_ready0, mode0, carry_in0;
   logic          out_valid0, out_ready0, carry_out0;
   logic [DW-1:0] data_a0, data_b0, sum0;
   logic          overflow0;

   int_serial_adder #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) u_dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid0),
      .in_ready  (in_ready0),
      .mode      (mode0),
      .data_a    (data_a0),
      .data_b    (data_b0),
      .carry_in  (carry_in0),
      .out_valid (out_valid0),
      .out_ready (out_ready0),
      .sum       (sum0),
      .carry_out (carry_out0)
`ifdef INT_SERIAL_ADDER_OVF_EN
      ,
      .overflow  (overflow0)
`endif
   );

   // ---------------- DUT 1: single chunk ----------------
   logic          in_valid1, in_ready1, mode1, carry_in1;
   logic          out_valid1, out_ready1, carry_out1;
   logic [DW-1:0] data_a1, data_b1, sum1;
   logic          overflow1;

   int_serial_adder #(.DATA_WIDTH(DW), .CHUNK_WIDTH(DW)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .mode      (mode1),
      .data_a    (data_a1),
      .data_b    (data_b1),
      .carry_in  (carry_in1),
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .sum       (sum1),
      .carry_out (carry_out1)
`ifdef INT_SERIAL_ADDER_OVF_EN
      ,
      .overflow  (overflow1)
`endif
   );

`ifndef INT_SERIAL_ADDER_OVF_EN
   assign overflow0 = 1'b0;
   assign overflow1 = 1'b0;
`endif

   // ---------------- scoreboard ----------------
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW:0]   exp_q[$];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW:0] ref_add(input logic m, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic cin);
      logic [DW-1:0] bb;
      bb = m ? b : '0;
      return {1'b0, a} + {1'b0, bb} + {{DW{1'b0}}, cin};
   endfunction

   function automatic logic ref_ovf(input logic m, input logic [DW-1:0] a,
                                    input logic [DW-1:0] b, input logic cin);
      logic [DW-1:0] bb;
      logic [DW:0]   r;
      bb = m ? b : '0;
      r  = ref_add(m, a, b, cin);
      return (a[DW-1] == bb[DW-1]) && (r[DW-1] != a[DW-1]);
   endfunction

   // ---------------- driver: one operation on DUT 0 ----------------
   // Called just after a falling edge; returns just after a falling edge.
   task automatic run_op0(input string tag, input logic m, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic cin,
                          input logic [DW-1:0] exp_sum, input logic exp_cout);
      mode0 = m; data_a0 = a; data_b0 = b; carry_in0 = cin;
      in_valid0 = 1'b1;
      @(negedge clk);
      in_valid0 = 1'b0;
      check_eq({tag, "_busy_in_ready"}, 64'(in_ready0), 64'd0);
      for (int k = 1; k <= N; k++) begin
         @(negedge clk);
         if (k == N - 1) check_eq({tag, "_early_valid"}, 64'(out_valid0), 64'd0);
      end
      check_eq({tag, "_out_valid"}, 64'(out_valid0), 64'd1);
      check_eq({tag, "_sum"}, 64'(sum0), 64'(exp_sum));
      check_eq({tag, "_carry_out"}, 64'(carry_out0), 64'(exp_cout));
`ifdef INT_SERIAL_ADDER_OVF_EN
      check_eq({tag, "_overflow"}, 64'(overflow0), 64'(ref_ovf(m, a, b, cin)));
`endif
      if (out_ready0) begin
         @(negedge clk);
         check_eq({tag, "_back_idle"}, 64'(in_ready0), 64'd1);
         check_eq({tag, "_valid_drop"}, 64'(out_valid0), 64'd0);
      end
   endtask

   // Safety net against a stuck run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      in_valid0 = 0; mode0 = 0; data_a0 = '0; data_b0 = '0; carry_in0 = 0; out_ready0 = 1;
      in_valid1 = 0; mode1 = 0; data_a1 = '0; data_b1 = '0; carry_in1 = 0; out_ready1 = 1;

      repeat (3) @(negedge clk);
      check_eq("rst_in_ready0", 64'(in_ready0), 64'd1);
      check_eq("rst_out_valid0", 64'(out_valid0), 64'd0);
      check_eq("rst_sum0", 64'(sum0), 64'd0);
      check_eq("rst_carry0", 64'(carry_out0), 64'd0);
      check_eq("rst_in_ready1", 64'(in_ready1), 64'd1);
      check_eq("rst_out_valid1", 64'(out_valid1), 64'd0);
`ifdef INT_SERIAL_ADDER_OVF_EN
      check_eq("rst_overflow0", 64'(overflow0), 64'd0);
      check_eq("rst_overflow1", 64'(overflow1), 64'd0);
`endif

      // Release reset and present operands at once: first edge must accept.
      rst_n = 1'b1;
      run_op0("inc_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
      run_op0("add_basic", 1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 32'h2143_6587, 1'b0);
      run_op0("inc_ign_b", 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 32'h1234_5678, 1'b0);
      run_op0("add_msb", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1);
      run_op0("add_ripple", 1'b1, 32'h00FF_FFFF, 32'h0000_0000, 1'b1, 32'h0100_0000, 1'b0);

      // Hold result in DONE with out_ready low while in_valid toggles.
      out_ready0 = 1'b0;
      run_op0("hold", 1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
      for (int i = 0; i < 10; i++) begin
         in_valid0 = (i % 2 == 0);
         mode0 = 1'b1; data_a0 = 32'hDEAD_BEEF; data_b0 = 32'h1111_1111; carry_in0 = 1'b1;
         @(negedge clk);
         check_eq("hold_valid", 64'(out_valid0), 64'd1);
         check_eq("hold_in_ready", 64'(in_ready0), 64'd0);
         check_eq("hold_sum", 64'(sum0), 64'h100);
         check_eq("hold_carry", 64'(carry_out0), 64'd0);
      end
      in_valid0 = 1'b0;
      out_ready0 = 1'b1;
      @(negedge clk);
      check_eq("hold_release_idle", 64'(in_ready0), 64'd1);
      check_eq("hold_release_valid", 64'(out_valid0), 64'd0);
      check_eq("hold_no_capture", 64'(sum0), 64'h100);

      // Reset while chunk 2 is in progress.
      mode0 = 1'b1; data_a0 = 32'h1234_5678; data_b0 = 32'h0F0F_0F0F; carry_in0 = 1'b0;
      in_valid0 = 1'b1;
      @(negedge clk);
      in_valid0 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_valid", 64'(out_valid0), 64'd0);
      check_eq("midrst_sum", 64'(sum0), 64'd0);
      check_eq("midrst_carry", 64'(carry_out0), 64'd0);
      check_eq("midrst_in_ready", 64'(in_ready0), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      run_op0("after_rst", 1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 32'h2143_6587, 1'b0);

      // Single-chunk instance: latency of one cycle.
      mode1 = 1'b1; data_a1 = 32'h7FFF_FFFF; data_b1 = 32'h0000_0001; carry_in1 = 1'b0;
      in_valid1 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0;
      check_eq("w1_busy_valid", 64'(out_valid1), 64'd0);
      check_eq("w1_busy_ready", 64'(in_ready1), 64'd0);
      @(negedge clk);
      check_eq("w1_valid", 64'(out_valid1), 64'd1);
      check_eq("w1_sum", 64'(sum1), 64'h8000_0000);
      check_eq("w1_carry", 64'(carry_out1), 64'd0);
`ifdef INT_SERIAL_ADDER_OVF_EN
      check_eq("w1_overflow", 64'(overflow1), 64'd1);
`endif
      @(negedge clk);
      check_eq("w1_idle", 64'(in_ready1), 64'd1);
      data_a1 = 32'hFFFF_FFFF; data_b1 = 32'h0000_0001;
      in_valid1 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0;
      @(negedge clk);
      check_eq("w1b_valid", 64'(out_valid1), 64'd1);
      check_eq("w1b_sum", 64'(sum1), 64'h0);
      check_eq("w1b_carry", 64'(carry_out1), 64'd1);
`ifdef INT_SERIAL_ADDER_OVF_EN
      check_eq("w1b_overflow", 64'(overflow1), 64'd0);
`endif
      @(negedge clk);

      // Back-to-back random operands, in_valid held high throughout.
      begin
         int accepts  = 0;
         int results  = 0;
         int last_acc = -1;
         logic [DW:0] exp_v;
         out_ready0 = 1'b1;
         mode0 = 1'b1;
         for (int cyc = 0; cyc < 80; cyc++) begin
            if (out_valid0) begin
               if (exp_q.size() == 0) begin
                  check_eq("b2b_unexpected_result", 64'd1, 64'd0);
               end else begin
                  exp_v = exp_q.pop_front();
                  check_eq("b2b_sum", 64'(sum0), 64'(exp_v[DW-1:0]));
                  check_eq("b2b_carry", 64'(carry_out0), 64'(exp_v[DW]));
               end
               results++;
            end
            if (in_ready0 && accepts < 8) begin
               if (last_acc >= 0) check_eq("b2b_interval", 64'(cyc - last_acc), 64'(N + 2));
               last_acc  = cyc;
               data_a0   = $urandom();
               data_b0   = $urandom();
               carry_in0 = 1'($urandom_range(0, 1));
               in_valid0 = 1'b1;
               exp_q.push_back(ref_add(1'b1, data_a0, data_b0, carry_in0));
               accepts++;
            end else if (accepts >= 8) begin
               in_valid0 = 1'b0;
            end else begin
               // Ignored while busy: scramble operands to expose any late capture.
               data_a0   = $urandom();
               data_b0   = $urandom();
               carry_in0 = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
         end
         check_eq("b2b_result_count", 64'(results), 64'd8);
         check_eq("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
